// File: rtl/memory_management_pkg.sv
// Shared constants for the CPU data-memory / switch front-end.
package memory_management_pkg;

   // Register map (byte addresses, word aligned)
   localparam logic [31:0] SW_ADDR       = 32'h0000_0000;
   localparam logic [31:0] OP_ADDR       = 32'h0000_0004;
   localparam logic [31:0] RAM_BASE_DFLT = 32'h0000_0100;

   // Op codes reported at OP_ADDR
   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_INIT = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_NOT  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XOR0 = 3'd5;
   localparam logic [2:0] OP_XOR1 = 3'd6;
   localparam logic [2:0] OP_XOR2 = 3'd7;

   // Bit positions inside the switch register
   localparam int SW_INIT = 0;
   localparam int SW_ADD  = 1;
   localparam int SW_NOT  = 2;
   localparam int SW_XOR  = 3;
   localparam int SW_XOR0 = 4;
   localparam int SW_XOR1 = 5;
   localparam int SW_XOR2 = 6;
   localparam int SW_W    = 7;

   // Address decode result
   typedef struct packed {
      logic sw_hit;
      logic op_hit;
      logic ram_hit;
   } dec_t;

   // Priority encoder: the lowest set switch bit selects the op code.
   // Scanning from the top lets the lowest hit overwrite the rest.
   function automatic logic [2:0] prio_enc(input logic [SW_W-1:0] sw);
      logic [2:0] op;
      op = OP_NONE;
      for (int i = SW_W - 1; i >= 0; i--) begin
         if (sw[i]) op = 3'(i + 1);
      end
      return op;
   endfunction

endpackage

// File: rtl/memory_management_data_ram.sv
// Data RAM: asynchronous read, synchronous write, contents not reset.
module data_ram #(
   parameter int WORDS = 256,
   parameter int IDX_W = $clog2(WORDS)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [WORDS];

   // Write port commits on the rising edge
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   // Read port follows the index with no latency
   assign rdata = mem[idx];

endmodule

// File: rtl/memory_management.sv
// CPU word port: switch status registers plus a data RAM window.
module memory_management
   import memory_management_pkg::*;
#(
   parameter int          RAM_WORDS = 256,
   parameter logic [31:0] RAM_BASE  = RAM_BASE_DFLT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        swxor2,
   input  logic        swxor1,
   input  logic        swxor0,
   input  logic        swxor,
   input  logic        swnot,
   input  logic        swadd,
   input  logic        swinit,
   input  logic        wboolean,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);

   localparam int          IDX_W   = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_END = RAM_BASE + 32'(4 * RAM_WORDS);

   logic [SW_W-1:0]  sw;
   logic [2:0]       op;
   dec_t             dec;
   logic [31:0]      ram_off;
   logic [IDX_W-1:0] ram_idx;
   logic [31:0]      ram_rdata;
   logic             ram_we;
   logic             unused_off;

   // Switch register: sampled every edge, reset has priority
   always_ff @(posedge clk) begin
      if (rst) begin
         sw <= '0;
      end else begin
         sw[SW_INIT] <= swinit;
         sw[SW_ADD]  <= swadd;
         sw[SW_NOT]  <= swnot;
         sw[SW_XOR]  <= swxor;
         sw[SW_XOR0] <= swxor0;
         sw[SW_XOR1] <= swxor1;
         sw[SW_XOR2] <= swxor2;
      end
   end

   assign op = prio_enc(sw);

   // Word offset into the RAM; only meaningful when ram_hit is set, since
   // addresses below the base wrap and would otherwise alias high words.
   assign ram_off    = address - RAM_BASE;
   assign ram_idx    = ram_off[IDX_W+1:2];
   assign unused_off = ^{ram_off[31:IDX_W+2], ram_off[1:0]};

   // Address decode, byte offset ignored
   always_comb begin
      dec         = '0;
      dec.sw_hit  = (address[31:2] == SW_ADDR[31:2]);
      dec.op_hit  = (address[31:2] == OP_ADDR[31:2]);
      dec.ram_hit = (address >= RAM_BASE) && (address < RAM_END);
   end

   // Registers are read-only; only the RAM window accepts stores
   assign ram_we = wboolean && !rst && dec.ram_hit;

   data_ram #(
      .WORDS(RAM_WORDS),
      .IDX_W(IDX_W)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .idx  (ram_idx),
      .wdata(wdata),
      .rdata(ram_rdata)
   );

   // Read mux: unmapped and reserved space returns zero
   always_comb begin
      rdata = '0;
      if (dec.sw_hit)       rdata = {{(32-SW_W){1'b0}}, sw};
      else if (dec.op_hit)  rdata = {29'b0, op};
      else if (dec.ram_hit) rdata = ram_rdata;
   end

endmodule

// File: tb/tb_memory_management.sv
// Directed bench for memory_management.
module tb_memory_management;

   logic        clk = 1'b0;
   logic        rst;
   logic        swxor2, swxor1, swxor0, swxor, swnot, swadd, swinit;
   logic        wboolean;
   logic [31:0] address;
   logic [31:0] wdata;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;
   logic [31:0] copied;

   memory_management dut (
      .clk     (clk),
      .rst     (rst),
      .swxor2  (swxor2),
      .swxor1  (swxor1),
      .swxor0  (swxor0),
      .swxor   (swxor),
      .swnot   (swnot),
      .swadd   (swadd),
      .swinit  (swinit),
      .wboolean(wboolean),
      .address (address),
      .wdata   (wdata),
      .rdata   (rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sw(input logic [6:0] v);
      {swxor2, swxor1, swxor0, swxor, swnot, swadd, swinit} = v;
   endtask

   task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
      address = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      address  = a;
      wdata    = d;
      wboolean = 1'b1;
      tick();
      wboolean = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wboolean = 1'b0; address = '0; wdata = '0;
      set_sw(7'h00);
      tick(); tick();
      rd(32'h000, "rst_sw", 32'h0);
      rd(32'h004, "rst_op", 32'h0);
      rst = 1'b0;

      // swadd + swxor1: visible only after one edge
      swadd = 1'b1; swxor1 = 1'b1;
      rd(32'h000, "sw_pre_edge", 32'h0);
      tick();
      rd(32'h000, "sw_22", 32'h22);
      rd(32'h004, "op_add", 32'h2);
      rd(32'h001, "sw_lowbits", 32'h22);

      // copy switch word into RAM
      address = 32'h000; #1; copied = rdata;
      wr(32'h100, copied);
      rd(32'h100, "ram_copy", 32'h22);

      // read-during-write at 0x100
      address = 32'h100; wdata = 32'h1234_5678; wboolean = 1'b1; #1;
      chk("rdw_old", rdata, 32'h22);
      tick();
      chk("rdw_new", rdata, 32'h1234_5678);
      wboolean = 1'b0;
      wr(32'h4FC, 32'hDEAD_BEEF);
      rd(32'h4FC, "ram_top", 32'hDEAD_BEEF);
      rd(32'h4FF, "ram_top_lb", 32'hDEAD_BEEF);
      rd(32'h100, "ram_base", 32'h1234_5678);
      rd(32'h102, "ram_base_lb", 32'h1234_5678);

      // stores outside the RAM window are dropped
      wr(32'h000, 32'hFFFF_FFFF);
      wr(32'h004, 32'hFFFF_FFFF);
      wr(32'h010, 32'hFFFF_FFFF);
      wr(32'h500, 32'hFFFF_FFFF);
      wr(32'h0FC, 32'hFFFF_FFFF);
      rd(32'h000, "ro_sw", 32'h22);
      rd(32'h004, "ro_op", 32'h2);
      rd(32'h010, "reserved", 32'h0);
      rd(32'h0FC, "reserved_top", 32'h0);
      rd(32'h500, "above_ram", 32'h0);
      rd(32'h100, "no_alias_lo", 32'h1234_5678);
      rd(32'h4FC, "no_alias_hi", 32'hDEAD_BEEF);

      // reset blocks RAM writes and wins over switch sampling
      wr(32'h104, 32'h1111_1111);
      rst = 1'b1; set_sw(7'h7F);
      address = 32'h104; wdata = 32'hAAAA_5555; wboolean = 1'b1;
      tick();
      wboolean = 1'b0;
      rd(32'h000, "rst_wins", 32'h0);
      rd(32'h004, "rst_op0", 32'h0);
      rd(32'h104, "rst_no_wr", 32'h1111_1111);
      rst = 1'b0;
      tick();
      rd(32'h000, "all_sw", 32'h7F);
      rd(32'h004, "op_init", 32'h1);

      // priority encoding cases
      set_sw(7'h40); tick();
      rd(32'h004, "op_xor2", 32'h7);
      rd(32'h000, "sw_40", 32'h40);
      set_sw(7'h0C); tick();
      rd(32'h004, "op_not", 32'h3);
      set_sw(7'h10); tick();
      rd(32'h004, "op_xor0", 32'h5);
      set_sw(7'h28); tick();
      rd(32'h004, "op_xor", 32'h4);
      set_sw(7'h00); tick();
      rd(32'h004, "op_none", 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_management.md
# memory_management

Memory-mapped data memory and switch front-end for the CPU. Presents one 32-bit word port to the core: reads are combinational, writes commit on the rising clock edge. It maps the board switches (operation selectors) into read-only status words and provides a 256-word data RAM. It sits between the CPU load/store path and the board I/O.

## Interface
Parameters:
- RAM_WORDS, 256, depth of the data RAM in 32-bit words; must be a power of two.
- RAM_BASE, 32'h100, byte base address of the data RAM.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- swxor2  in  1  operation switch, XOR variant 2
- swxor1  in  1  operation switch, XOR variant 1
- swxor0  in  1  operation switch, XOR variant 0
- swxor  in  1  operation switch, plain XOR
- swnot  in  1  operation switch, NOT
- swadd  in  1  operation switch, ADD
- swinit  in  1  operation switch, init/start
- wboolean  in  1  write enable for the current address
- address  in  32  byte address; bits [1:0] ignored (word access only)
- wdata  in  32  write data
- rdata  out  32  read data for the current address

## Operation
- Switch register SW[6:0]: sampled every rising edge when rst=0.
  - Bit mapping: bit0 swinit, bit1 swadd, bit2 swnot, bit3 swxor, bit4 swxor0, bit5 swxor1, bit6 swxor2.
- Op code OP[2:0]: combinational priority encode of SW, lowest bit wins.
  - swinit=1, swadd=2, swnot=3, swxor=4, swxor0=5, swxor1=6, swxor2=7, none set=0.
- Address map (word-aligned, address[1:0] ignored):
  - 0x000: {25'b0, SW}, read-only.
  - 0x004: {29'b0, OP}, read-only.
  - 0x008–0x0FF: reserved, reads 0.
  - RAM_BASE to RAM_BASE+4*RAM_WORDS-1 (0x100–0x4FF): data RAM, index = (address-RAM_BASE)[9:2].
  - Everything else: reads 0.
- Writes with wboolean=1:
  - Inside the RAM window: store wdata at the indexed word.
  - Anywhere else: silently ignored. Registers are not writable.
- Reset: SW cleared to 0 (OP reads 0). RAM contents are not cleared. RAM writes are suppressed while rst=1.

## Timing
- rdata is purely combinational from address, SW and the RAM array. There is no read latency.
- RAM write commits at the rising edge where wboolean=1 and rst=0. New data is visible on rdata immediately after that edge.
- Read-during-write to the same word: before the edge rdata shows the old value; after the edge it shows the new value.
- Switch changes reach rdata (0x000/0x004) one edge after they occur.
- Switches are assumed already debounced/synchronous; no metastability stage.
- rst and switch sampling on the same edge: reset wins, SW=0.
- Address outside all windows with wboolean=1: no state change, rdata=0.

## Structure
- Package memory_management_pkg holds:
  - Address constants: SW_ADDR=0x000, OP_ADDR=0x004, RAM_BASE default.
  - Op code localparams: OP_NONE, OP_INIT, OP_ADD, OP_NOT, OP_XOR, OP_XOR0, OP_XOR1, OP_XOR2.
  - Switch bit index constants.
- One sub-module, data_ram: RAM_WORDS×32, async read, sync write, no reset.
- Top level contains the switch register, priority encoder, address decode and read mux.

## Test plan
- Reset, then set swadd=1 and swxor1=1, clock once. Read 0x000 -> 0x00000022; read 0x004 -> 0x00000002.
- Read 0x000 and copy the result into wdata. Set address=0x100, wboolean=1, clock. Set wboolean=0, read 0x100 -> the copied switch word.
- Write 0xDEADBEEF to 0x4FC and 0x12345678 to 0x100. Read back both, and read 0x102 -> 0x12345678 (low address bits ignored).
- Write 0xFFFFFFFF to 0x000, 0x004, 0x010 and 0x500, then read each. 0x000/0x004 -> switch-derived values; 0x010 and 0x500 -> 0.
- Assert rst=1 with all switches high and wboolean=1 at 0x104 with wdata=0xAAAA5555, clock. Read 0x000 -> 0, and 0x104 is unchanged. Release reset and clock: 0x000 -> 0x7F, 0x004 -> 1.
- Set only swxor2, clock. Read 0x004 -> 7; then with no switch set, clock, read 0x004 -> 0.
